speriph_plug_arbiter: RTL and testbench
=======================================

Name: speriph_plug_arbiter

Overview:
- Parametrised N-to-1 combiner that merges several cluster peripheral-interconnect slave plugs onto one peripheral target port, e.g. event unit, timer or HWPE config.
- Replaces the fixed 2-plug combinational priority mux used today.
- Adds round-robin arbitration, request hold under back-pressure, and in-order response routing back to the issuing plug through an outstanding-transaction FIFO.
- Instantiated inside cluster_peripherals between the speriph plug array and each multi-plug peripheral.

Parameters:
- NB_PLUGS, 2, number of slave plugs merged (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- ID_WIDTH, 5, transaction ID width (NB_CORES+1).
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- plug_req_i  in  NB_PLUGS  per-plug request.
- plug_add_i  in  NB_PLUGS x ADDR_WIDTH  per-plug address.
- plug_wen_i  in  NB_PLUGS  per-plug write-enable, 0 = write.
- plug_wdata_i  in  NB_PLUGS x DATA_WIDTH  per-plug write data.
- plug_be_i  in  NB_PLUGS x DATA_WIDTH/8  per-plug byte enables.
- plug_id_i  in  NB_PLUGS x ID_WIDTH  per-plug transaction ID.
- plug_gnt_o  out  NB_PLUGS  per-plug grant.
- plug_r_valid_o  out  NB_PLUGS  per-plug response valid.
- plug_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all plugs.
- plug_r_opc_o  out  1  response error, broadcast.
- plug_r_id_o  out  ID_WIDTH  response ID, broadcast.
- m_req_o, m_add_o, m_wen_o, m_wdata_o, m_be_o, m_id_o  out  (widths as above)  request to the target.
- m_gnt_i  in  1  target grant.
- m_r_valid_i, m_r_rdata_i, m_r_opc_i, m_r_id_i  in  (widths as above)  target response.
- err_o  out  1  sticky protocol-error flag.

Interface decision: a single clock, clk_i; rst_ni is synchronous and active-low.

Behaviour:
- Reset: clear on a clk_i edge with rst_ni=0.
  - rr_ptr=0, lock=0, FIFO empty, err_o=0.
  - All plug_gnt_o and plug_r_valid_o are 0 while reset is asserted.
- Arbitration (combinational):
  - The winner is the first requesting plug found scanning from rr_ptr upward, modulo NB_PLUGS.
  - m_* request fields are driven from the winner.
  - m_req_o = |plug_req_i & ~fifo_full_eff.
  - plug_gnt_o[w] = m_gnt_i & m_req_o; all other grants are 0.
- Handshake: an accepted transfer is m_req_o & m_gnt_i. On accept:
  - push the winner index into the FIFO;
  - rr_ptr <= (w+1) mod NB_PLUGS.
- Hold rule: if m_req_o=1 and m_gnt_i=0, latch the winner and set lock.
  - While locked, the latched plug stays selected even if a higher-priority plug requests.
  - Lock clears on accept.
  - If the locked plug drops req, lock clears, err_o is set, and arbitration resumes the same cycle.
- Response routing: in order, with zero added latency.
  - plug_r_valid_o[i] = m_r_valid_i & ~fifo_empty & (head==i).
  - r_rdata, r_opc and r_id pass through.
  - The FIFO pops on m_r_valid_i.
- Full FIFO: fifo_full_eff = full & ~m_r_valid_i, i.e. a simultaneous pop frees a slot and a push is allowed the same cycle.
  - With FIFO depth 1 and a target answering the cycle after grant, back-to-back accepts sustain one transfer per cycle.
- Empty FIFO: m_r_valid_i is dropped, with no plug r_valid, and err_o is set.
- Simultaneous push and pop on an empty FIFO: the response belongs to the earlier transaction. Because the FIFO is empty, this is still an error.
- Reset mid-transaction: outstanding entries are discarded, and later responses raise err_o.
- Index width: IDX_W = max(1, $clog2(NB_PLUGS)). The occupancy counter is $clog2(MAX_OUTSTANDING+1) bits and never wraps.

Optional Feature:
- Macro: SPERIPH_ARB_STALL_CNT_EN.
- With the macro defined: adds output stall_cnt_o, NB_PLUGS x 16.
  - Counter i increments each cycle plug_req_i[i]=1 and plug_gnt_o[i]=0.
  - Counters saturate at 16'hFFFF and reset to 0.
- Without the macro: the port is absent and no counter logic is generated.

Decomposition:
- Package pulp_cluster_package gains:
  - constant NB_SPERIPH_PLUGS_EU, reused as the NB_PLUGS value;
  - typedef speriph_req_t (add, wen, wdata, be, id);
  - typedef speriph_rsp_t (rdata, opc, id).
- Natural sub-module: speriph_arb_id_fifo, a parametrised index FIFO with push/pop/full/empty and simultaneous push-pop support.

Test Plan:
- Single plug: plug1 req, target gnt=1, r_valid next cycle → plug_gnt_o=2'b10, then plug_r_valid_o=2'b10 with rdata 0xDEADBEEF.
- Fairness: NB_PLUGS=4, all req continuously, gnt=1 → grant order 0,1,2,3,0.
- Hold: plugs 0 and 2 req, gnt=0 for 3 cycles, then 1 → m_add_o stays at plug0 address throughout; plug2 is granted the next cycle.
- FIFO full: MAX_OUTSTANDING=2, delay responses → third request sees m_req_o=0 until the first r_valid, then is accepted in that same cycle.
- Spurious response: r_valid with FIFO empty → no plug r_valid, err_o=1, held until reset.
- With SPERIPH_ARB_STALL_CNT_EN: plug1 blocked 5 cycles → stall_cnt_o[1]=5; 70000 blocked cycles → 0xFFFF.

Source files
------------

// File: rtl/speriph_plug_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : speriph_plug_arbiter_pkg
// Purpose  : Shared constants, peripheral-plug transaction types and a small
//            index-width helper for the speriph plug arbiter slice.
// Contents : NB_SPERIPH_PLUGS_EU  - plug count merged in front of the event unit
//            speriph_req_t        - request payload (add, wen, wdata, be, id)
//            speriph_rsp_t        - response payload (rdata, opc, id)
//            idx_width()          - max(1, clog2(n))
// Revision : 1.0 - initial release
// ============================================================================
package speriph_plug_arbiter_pkg;

  localparam int NB_SPERIPH_PLUGS_EU = 2;

  localparam int SPERIPH_ADDR_WIDTH = 32;
  localparam int SPERIPH_DATA_WIDTH = 32;
  localparam int SPERIPH_ID_WIDTH   = 5;
  localparam int SPERIPH_BE_WIDTH   = SPERIPH_DATA_WIDTH / 8;

  typedef struct packed {
    logic [SPERIPH_ADDR_WIDTH-1:0] add;
    logic                          wen;
    logic [SPERIPH_DATA_WIDTH-1:0] wdata;
    logic [SPERIPH_BE_WIDTH-1:0]   be;
    logic [SPERIPH_ID_WIDTH-1:0]   id;
  } speriph_req_t;

  typedef struct packed {
    logic [SPERIPH_DATA_WIDTH-1:0] rdata;
    logic                          opc;
    logic [SPERIPH_ID_WIDTH-1:0]   id;
  } speriph_rsp_t;

  // A single-plug index still needs one bit to exist as a signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/speriph_plug_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : speriph_plug_arbiter_id_fifo
// Purpose  : Small FIFO holding the plug index of each outstanding request so
//            responses can be steered back in issue order.
// Ports    : clk_i, rst_ni (sync, active-low)
//            push_i/data_i  - enqueue an index
//            pop_i          - dequeue the head (ignored when empty)
//            head_o         - oldest index
//            full_o/empty_o - occupancy flags
//            A push and a pop in the same cycle are both honoured, including
//            when the FIFO is full.
// Revision : 1.0 - initial release
// ============================================================================
module speriph_plug_arbiter_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/speriph_plug_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : speriph_plug_arbiter
// Purpose  : Merges NB_PLUGS peripheral-interconnect slave plugs onto a single
//            target port. Round-robin arbitration, request hold while the
//            target stalls, in-order response routing through an index FIFO,
//            and a sticky protocol-error flag.
// Ports    : clk_i, rst_ni          - clock, sync active-low reset
//            plug_*_i / plug_gnt_o  - per-plug request side (flattened vectors)
//            plug_r_*_o             - response side, valid per plug, payload
//                                     broadcast
//            m_*_o / m_gnt_i        - request to the target
//            m_r_*_i                - response from the target
//            err_o                  - sticky: spurious response or a held
//                                     request withdrawn before grant
//            stall_cnt_o            - per-plug 16-bit saturating stall counters
//                                     (only with SPERIPH_ARB_STALL_CNT_EN)
// Macro    : SPERIPH_ARB_STALL_CNT_EN enables the stall counters and port.
// Revision : 1.0 - initial release
// ============================================================================
module speriph_plug_arbiter
  import speriph_plug_arbiter_pkg::*;
#(
  parameter int NB_PLUGS        = NB_SPERIPH_PLUGS_EU,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NB_PLUGS-1:0]            plug_req_i,
  input  logic [NB_PLUGS*ADDR_WIDTH-1:0] plug_add_i,
  input  logic [NB_PLUGS-1:0]            plug_wen_i,
  input  logic [NB_PLUGS*DATA_WIDTH-1:0] plug_wdata_i,
  input  logic [NB_PLUGS*DATA_WIDTH/8-1:0] plug_be_i,
  input  logic [NB_PLUGS*ID_WIDTH-1:0]   plug_id_i,
  output logic [NB_PLUGS-1:0]            plug_gnt_o,
  output logic [NB_PLUGS-1:0]            plug_r_valid_o,
  output logic [DATA_WIDTH-1:0]          plug_r_rdata_o,
  output logic                           plug_r_opc_o,
  output logic [ID_WIDTH-1:0]            plug_r_id_o,
  output logic                           m_req_o,
  output logic [ADDR_WIDTH-1:0]          m_add_o,
  output logic                           m_wen_o,
  output logic [DATA_WIDTH-1:0]          m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        m_be_o,
  output logic [ID_WIDTH-1:0]            m_id_o,
  input  logic                           m_gnt_i,
  input  logic                           m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          m_r_rdata_i,
  input  logic                           m_r_opc_i,
  input  logic [ID_WIDTH-1:0]            m_r_id_i,
`ifdef SPERIPH_ARB_STALL_CNT_EN
  output logic [NB_PLUGS*16-1:0]         stall_cnt_o,
`endif
  output logic                           err_o
);

  localparam int IDX_W = idx_width(NB_PLUGS);
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0] rr_ptr;
  logic             lock;
  logic [IDX_W-1:0] lock_idx;
  logic             lock_hold;
  logic             lock_drop;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W:0]   scan_sum;
  logic             scan_found;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_full_eff;
  logic [IDX_W-1:0] fifo_head;
  logic             rsp_routed;

  // Round-robin scan: first requester at or above rr_ptr, wrapping.
  always_comb begin
    scan_idx   = '0;
    scan_found = 1'b0;
    scan_sum   = '0;
    for (int k = 0; k < NB_PLUGS; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(NB_PLUGS)) scan_sum = scan_sum - (IDX_W+1)'(NB_PLUGS);
      if (!scan_found && plug_req_i[scan_sum[IDX_W-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = scan_sum[IDX_W-1:0];
      end
    end
  end

  // A stalled request keeps its slot; if its plug withdraws, arbitration
  // falls back to the scan in that same cycle.
  assign lock_hold = lock & plug_req_i[lock_idx];
  assign lock_drop = lock & ~plug_req_i[lock_idx];
  assign winner    = lock_hold ? lock_idx : scan_idx;

  assign any_req       = |plug_req_i;
  assign fifo_full_eff = fifo_full & ~m_r_valid_i;
  assign m_req_o       = any_req & ~fifo_full_eff;
  assign accept        = m_req_o & m_gnt_i;
  assign rsp_routed    = m_r_valid_i & ~fifo_empty;

  always_comb begin
    m_add_o   = '0;
    m_wen_o   = 1'b1;
    m_wdata_o = '0;
    m_be_o    = '0;
    m_id_o    = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      if (winner == IDX_W'(i)) begin
        m_add_o   = plug_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_wen_o   = plug_wen_i[i];
        m_wdata_o = plug_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        m_be_o    = plug_be_i[i*BE_W +: BE_W];
        m_id_o    = plug_id_i[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  // Grants and response valids are forced low while reset is held.
  always_comb begin
    plug_gnt_o     = '0;
    plug_r_valid_o = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      plug_gnt_o[i]     = rst_ni & accept & (winner == IDX_W'(i));
      plug_r_valid_o[i] = rst_ni & rsp_routed & (fifo_head == IDX_W'(i));
    end
  end

  assign plug_r_rdata_o = m_r_rdata_i;
  assign plug_r_opc_o   = m_r_opc_i;
  assign plug_r_id_o    = m_r_id_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err_o    <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (winner == IDX_W'(NB_PLUGS - 1)) ? '0 : winner + IDX_W'(1);
        lock   <= 1'b0;
      end else if (m_req_o) begin
        lock     <= 1'b1;
        lock_idx <= winner;
      end else if (lock_drop) begin
        lock <= 1'b0;
      end
      // A response with nothing outstanding is dropped and flagged.
      if (lock_drop || (m_r_valid_i && fifo_empty)) err_o <= 1'b1;
    end
  end

  speriph_plug_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (winner),
    .pop_i   (m_r_valid_i),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SPERIPH_ARB_STALL_CNT_EN
  for (genvar i = 0; i < NB_PLUGS; i++) begin : g_stall_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt <= '0;
      end else if (plug_req_i[i] && !plug_gnt_o[i] && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign stall_cnt_o[i*16 +: 16] = cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_speriph_plug_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_speriph_plug_arbiter
// Purpose  : Self-checking bench for speriph_plug_arbiter (4 plugs, 2
//            outstanding). A queue-based reference model is checked every
//            cycle; directed scenarios add literal expectations.
// Macro    : SPERIPH_ARB_STALL_CNT_EN adds the stall-counter scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speriph_plug_arbiter;

  localparam int NB  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 5;
  localparam int MAX = 2;

  logic              clk;
  logic              rst_ni;
  logic [NB-1:0]     plug_req;
  logic [NB*AW-1:0]  plug_add;
  logic [NB-1:0]     plug_wen;
  logic [NB*DW-1:0]  plug_wdata;
  logic [NB*4-1:0]   plug_be;
  logic [NB*IW-1:0]  plug_id;
  logic [NB-1:0]     plug_gnt;
  logic [NB-1:0]     plug_rvalid;
  logic [DW-1:0]     plug_rdata;
  logic              plug_ropc;
  logic [IW-1:0]     plug_rid;
  logic              m_req;
  logic [AW-1:0]     m_add;
  logic              m_wen;
  logic [DW-1:0]     m_wdata;
  logic [3:0]        m_be;
  logic [IW-1:0]     m_id;
  logic              m_gnt;
  logic              m_r_valid;
  logic [DW-1:0]     m_r_rdata;
  logic              m_r_opc;
  logic [IW-1:0]     m_r_id;
  logic              err;
`ifdef SPERIPH_ARB_STALL_CNT_EN
  logic [NB*16-1:0]  stall_cnt;
`endif

  speriph_plug_arbiter #(
    .NB_PLUGS        (NB),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .ID_WIDTH        (IW),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .plug_req_i     (plug_req),
    .plug_add_i     (plug_add),
    .plug_wen_i     (plug_wen),
    .plug_wdata_i   (plug_wdata),
    .plug_be_i      (plug_be),
    .plug_id_i      (plug_id),
    .plug_gnt_o     (plug_gnt),
    .plug_r_valid_o (plug_rvalid),
    .plug_r_rdata_o (plug_rdata),
    .plug_r_opc_o   (plug_ropc),
    .plug_r_id_o    (plug_rid),
    .m_req_o        (m_req),
    .m_add_o        (m_add),
    .m_wen_o        (m_wen),
    .m_wdata_o      (m_wdata),
    .m_be_o         (m_be),
    .m_id_o         (m_id),
    .m_gnt_i        (m_gnt),
    .m_r_valid_i    (m_r_valid),
    .m_r_rdata_i    (m_r_rdata),
    .m_r_opc_i      (m_r_opc),
    .m_r_id_i       (m_r_id),
`ifdef SPERIPH_ARB_STALL_CNT_EN
    .stall_cnt_o    (stall_cnt),
`endif
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Per-plug request payloads.
  logic [AW-1:0] exp_add   [NB];
  logic          exp_wen   [NB];
  logic [DW-1:0] exp_wdata [NB];
  logic [3:0]    exp_be    [NB];
  logic [IW-1:0] exp_id    [NB];

  // Reference model state: next preferred plug, held plug (-1 none),
  // queue of issuing plugs for outstanding requests, sticky error.
  int  mdl_rr   = 0;
  int  mdl_held = -1;
  int  mdl_q[$];
  bit  mdl_err  = 1'b0;
  int  mdl_stall [NB];

  task automatic model_cycle();
    int       w;
    bit       found;
    bit       full_eff;
    bit       mreq;
    logic [NB-1:0] g_exp;
    logic [NB-1:0] rv_exp;
    w = 0;
    found = 1'b0;
    if (mdl_held >= 0 && plug_req[mdl_held]) begin
      w = mdl_held;
      found = 1'b1;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (!found && plug_req[(mdl_rr + k) % NB]) begin
          w = (mdl_rr + k) % NB;
          found = 1'b1;
        end
      end
    end
    full_eff = (mdl_q.size() == MAX) && !m_r_valid;
    mreq     = found && !full_eff;
    g_exp    = '0;
    rv_exp   = '0;
    if (rst_ni && mreq && m_gnt) g_exp[w] = 1'b1;
    if (rst_ni && m_r_valid && mdl_q.size() > 0) rv_exp[mdl_q[0]] = 1'b1;

    if (found) begin
      check("m_add",   m_add,   exp_add[w]);
      check("m_wen",   m_wen,   exp_wen[w]);
      check("m_wdata", m_wdata, exp_wdata[w]);
      check("m_be",    m_be,    exp_be[w]);
      check("m_id",    m_id,    exp_id[w]);
    end
    check("m_req",    m_req,       mreq);
    check("plug_gnt", plug_gnt,    g_exp);
    check("r_valid",  plug_rvalid, rv_exp);
    check("r_rdata",  plug_rdata,  m_r_rdata);
    check("r_opc",    plug_ropc,   m_r_opc);
    check("r_id",     plug_rid,    m_r_id);
    check("err",      err,         mdl_err);
`ifdef SPERIPH_ARB_STALL_CNT_EN
    for (int i = 0; i < NB; i++) check("stall_cnt", stall_cnt[i*16 +: 16], mdl_stall[i]);
`endif

    if (!rst_ni) begin
      mdl_rr = 0;
      mdl_held = -1;
      mdl_q.delete();
      mdl_err = 1'b0;
      for (int i = 0; i < NB; i++) mdl_stall[i] = 0;
    end else begin
      if (mdl_held >= 0 && !plug_req[mdl_held]) mdl_err = 1'b1;
      if (m_r_valid && mdl_q.size() == 0) mdl_err = 1'b1;
      for (int i = 0; i < NB; i++)
        if (plug_req[i] && !g_exp[i] && mdl_stall[i] < 65535) mdl_stall[i]++;
      if (m_r_valid && mdl_q.size() > 0) void'(mdl_q.pop_front());
      if (mreq && m_gnt) begin
        mdl_q.push_back(w);
        mdl_rr = (w + 1) % NB;
        mdl_held = -1;
      end else if (mreq) begin
        mdl_held = w;
      end else if (mdl_held >= 0 && !plug_req[mdl_held]) begin
        mdl_held = -1;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [NB-1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rdata);
    plug_req  = req;
    m_gnt     = gnt;
    m_r_valid = rv;
    m_r_rdata = rdata;
    m_r_opc   = rdata[0];
    m_r_id    = rdata[IW-1:0];
  endtask

  logic [NB-1:0] fair_got [5];
  logic [NB-1:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    for (int i = 0; i < NB; i++) mdl_stall[i] = 0;
    for (int i = 0; i < NB; i++) begin
      exp_add[i]   = 32'hA000_0000 | (i << 4);
      exp_wen[i]   = (i % 2 == 1);
      exp_wdata[i] = 32'h1111_1111 * (i + 1);
      exp_be[i]    = 4'(1 << i);
      exp_id[i]    = 5'(i + 1);
      plug_add[i*AW +: AW]   = exp_add[i];
      plug_wen[i]            = exp_wen[i];
      plug_wdata[i*DW +: DW] = exp_wdata[i];
      plug_be[i*4 +: 4]      = exp_be[i];
      plug_id[i*IW +: IW]    = exp_id[i];
    end
    rst_ni = 1'b0;
    drive(4'hF, 1'b1, 1'b0, '0);

    // Reset: no grants even with every plug requesting and the target ready.
    step(); settle();
    check("rst_gnt", plug_gnt, 4'b0000);
    check("rst_rvalid", plug_rvalid, 4'b0000);
    step(); rst_ni = 1'b1; drive(4'h0, 1'b0, 1'b0, '0); settle();
    check("post_rst_err", err, 1'b0);
    check("post_rst_gnt", plug_gnt, 4'b0000);
    check("post_rst_mreq", m_req, 1'b0);

    // Single plug, response next cycle.
    step(); drive(4'b0010, 1'b1, 1'b0, '0); settle();
    check("single_gnt", plug_gnt, 4'b0010);
    check("single_add", m_add, 32'hA000_0010);
    step(); drive(4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF); settle();
    check("single_rvalid", plug_rvalid, 4'b0010);
    check("single_rdata", plug_rdata, 32'hDEAD_BEEF);
    step(); drive(4'b0000, 1'b0, 1'b0, '0);

    // Fairness from a fresh reset, responses one cycle after each grant.
    step(); rst_ni = 1'b0; drive(4'hF, 1'b1, 1'b0, '0); settle();
    check("rst2_gnt", plug_gnt, 4'b0000);
    for (int f = 0; f < 5; f++) begin
      step(); rst_ni = 1'b1; drive(4'hF, 1'b1, (f > 0), 32'h100 + f); settle();
      fair_got[f] = plug_gnt;
    end
    step(); drive(4'h0, 1'b0, 1'b1, 32'h200);
    for (int f = 0; f < 5; f++) check("fair_order", fair_got[f], fair_exp[f]);

    // Hold under back-pressure.
    step(); rst_ni = 1'b0; drive(4'h0, 1'b0, 1'b0, '0);
    step(); rst_ni = 1'b1; drive(4'b0101, 1'b0, 1'b0, '0); settle();
    check("hold_add_c1", m_add, 32'hA000_0000);
    step(); settle();
    check("hold_add_c2", m_add, 32'hA000_0000);
    step(); settle();
    check("hold_add_c3", m_add, 32'hA000_0000);
    check("hold_gnt_c3", plug_gnt, 4'b0000);
    step(); drive(4'b0101, 1'b1, 1'b0, '0); settle();
    check("hold_accept", plug_gnt, 4'b0001);
    step(); drive(4'b0100, 1'b1, 1'b0, '0); settle();
    check("hold_next", plug_gnt, 4'b0100);
    step(); drive(4'h0, 1'b0, 1'b1, 32'h300); settle();
    check("hold_rsp0", plug_rvalid, 4'b0001);
    step(); drive(4'h0, 1'b0, 1'b1, 32'h301); settle();
    check("hold_rsp2", plug_rvalid, 4'b0100);
    // rr now favours plug 3, but a held plug 1 keeps the port.
    step(); drive(4'b0010, 1'b0, 1'b0, '0); settle();
    check("lock_add_a", m_add, 32'hA000_0010);
    step(); drive(4'b1010, 1'b0, 1'b0, '0); settle();
    check("lock_add_b", m_add, 32'hA000_0010);
    step(); drive(4'b1010, 1'b1, 1'b0, '0); settle();
    check("lock_gnt", plug_gnt, 4'b0010);
    step(); drive(4'h0, 1'b0, 1'b1, 32'h302); settle();
    check("lock_rsp", plug_rvalid, 4'b0010);

    // FIFO full: third request waits for the first response, then goes.
    step(); drive(4'b0001, 1'b1, 1'b0, '0); settle();
    check("full_gnt1", plug_gnt, 4'b0001);
    step(); settle();
    check("full_gnt2", plug_gnt, 4'b0001);
    step(); settle();
    check("full_mreq_a", m_req, 1'b0);
    check("full_gnt_a", plug_gnt, 4'b0000);
    step(); settle();
    check("full_mreq_b", m_req, 1'b0);
    step(); drive(4'b0001, 1'b1, 1'b1, 32'h400); settle();
    check("full_mreq_pop", m_req, 1'b1);
    check("full_gnt_pop", plug_gnt, 4'b0001);
    check("full_rvalid_pop", plug_rvalid, 4'b0001);
    step(); drive(4'h0, 1'b0, 1'b1, 32'h401); settle();
    check("full_drain1", plug_rvalid, 4'b0001);
    step(); drive(4'h0, 1'b0, 1'b1, 32'h402); settle();
    check("full_drain2", plug_rvalid, 4'b0001);
    step(); drive(4'h0, 1'b0, 1'b0, '0); settle();
    check("full_err", err, 1'b0);

    // Spurious response.
    step(); drive(4'h0, 1'b0, 1'b1, 32'h500); settle();
    check("spur_rvalid", plug_rvalid, 4'b0000);
    step(); drive(4'h0, 1'b0, 1'b0, '0); settle();
    check("spur_err", err, 1'b1);
    repeat (3) step();
    settle();
    check("spur_err_sticky", err, 1'b1);
    step(); rst_ni = 1'b0;
    step(); rst_ni = 1'b1; settle();
    check("spur_err_cleared", err, 1'b0);

    // Held plug withdraws; another plug is arbitrated the same cycle.
    step(); drive(4'b1000, 1'b0, 1'b0, '0); settle();
    check("drop_add", m_add, 32'hA000_0030);
    check("drop_mreq", m_req, 1'b1);
    step(); drive(4'b0010, 1'b1, 1'b0, '0); settle();
    check("drop_regnt", plug_gnt, 4'b0010);
    check("drop_err_pre", err, 1'b0);
    step(); drive(4'h0, 1'b0, 1'b1, 32'h600); settle();
    check("drop_rsp", plug_rvalid, 4'b0010);
    check("drop_err", err, 1'b1);
    step(); drive(4'h0, 1'b0, 1'b0, '0);

    // Reset with a request outstanding discards it.
    step(); rst_ni = 1'b0;
    step(); rst_ni = 1'b1; drive(4'b0100, 1'b1, 1'b0, '0); settle();
    check("mid_gnt", plug_gnt, 4'b0100);
    step(); rst_ni = 1'b0; drive(4'h0, 1'b0, 1'b0, '0);
    step(); rst_ni = 1'b1; drive(4'h0, 1'b0, 1'b1, 32'h700); settle();
    check("mid_rvalid", plug_rvalid, 4'b0000);
    check("mid_err_pre", err, 1'b0);
    step(); drive(4'h0, 1'b0, 1'b0, '0); settle();
    check("mid_err", err, 1'b1);

`ifdef SPERIPH_ARB_STALL_CNT_EN
    step(); rst_ni = 1'b0;
    step(); rst_ni = 1'b1; drive(4'b0010, 1'b0, 1'b0, '0);
    repeat (5) step();
    settle();
    check("stall_5", stall_cnt[16 +: 16], 16'd5);
    check("stall_other", stall_cnt[0 +: 16], 16'd0);
    repeat (70000) step();
    settle();
    check("stall_sat", stall_cnt[16 +: 16], 16'hFFFF);
    step(); drive(4'h0, 1'b0, 1'b0, '0);
`endif

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
